// File: rtl/lexington_pkg.sv
// Shared types for the AXI4-Lite subordinate: FSM state encoding and response codes.
package lexington_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_COLLECT,
    WR_EXEC,
    WR_RESP,
    RD_EXEC,
    RD_WAIT,
    RD_RESP
  } state_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

endpackage

// File: rtl/axi4_lite.sv
// AXI4-Lite bus bundle with manager and subordinate views.
interface axi4_lite #(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  awvalid;
  logic                  awready;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic                  wvalid;
  logic                  wready;
  logic [WIDTH-1:0]      wdata;
  logic [WIDTH/8-1:0]    wstrb;
  logic                  bvalid;
  logic                  bready;
  logic [1:0]            bresp;
  logic                  arvalid;
  logic                  arready;
  logic [ADDR_WIDTH-1:0] araddr;
  logic                  rvalid;
  logic                  rready;
  logic [WIDTH-1:0]      rdata;
  logic [1:0]            rresp;

  modport manager (
    output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );

  modport subordinate (
    input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
    output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
  );
endinterface

// File: rtl/axi4_lite_subordinate.sv
// AXI4-Lite subordinate bridging one transaction at a time onto a simple
// strobed local register bus, with round-robin read/write arbitration.
module axi4_lite_subordinate
  import lexington_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  axi4_lite.subordinate         axi_s,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic                  rd_en,
  output logic                  wr_en,
  output logic [WIDTH-1:0]      wr_data,
  output logic [WIDTH/8-1:0]    wr_strobe,
  input  logic [WIDTH-1:0]      rd_data,
  input  logic                  access_fault
);

  state_e           state, state_next;
  logic             aw_got, w_got, last_was_write;
  logic             write_req, contested;
  logic             aw_rdy, w_rdy, ar_rdy;
  logic             aw_hs, w_hs, ar_hs;
  logic [WIDTH-1:0] rdata;
  logic [1:0]       bresp, rresp;

  assign write_req = axi_s.awvalid | axi_s.wvalid;
  assign contested = write_req & axi_s.arvalid;

  // Readies are gated with rst_n because the held IDLE state would otherwise
  // advertise them during reset.
  always_comb begin
    // NOTE: every output gets a default first, so no path can infer a latch.
    aw_rdy = 1'b0;
    w_rdy  = 1'b0;
    ar_rdy = 1'b0;
    case (state)
      IDLE: begin
        aw_rdy = rst_n & ~(contested & last_was_write);
        w_rdy  = rst_n & ~(contested & last_was_write);
        ar_rdy = rst_n & ~(contested & ~last_was_write);
      end
      WR_COLLECT: begin
        aw_rdy = ~aw_got;
        w_rdy  = ~w_got;
      end
      default: ;
    endcase
  end

  assign aw_hs = axi_s.awvalid & aw_rdy;
  assign w_hs  = axi_s.wvalid & w_rdy;
  assign ar_hs = axi_s.arvalid & ar_rdy;

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (ar_hs)              state_next = RD_EXEC;
        else if (aw_hs && w_hs) state_next = WR_EXEC;
        else if (aw_hs || w_hs) state_next = WR_COLLECT;
      end
      WR_COLLECT: if ((aw_got || aw_hs) && (w_got || w_hs)) state_next = WR_EXEC;
      WR_EXEC:    state_next = WR_RESP;
      WR_RESP:    if (axi_s.bready) state_next = IDLE;
      RD_EXEC:    state_next = RD_WAIT;
      RD_WAIT:    state_next = RD_RESP;
      RD_RESP:    if (axi_s.rready) state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // Datapath registers are reset too: the local bus and response fields
      // must read zero/OKAY while reset is held.
      state          <= IDLE;
      addr           <= '0;
      wr_data        <= '0;
      wr_strobe      <= '0;
      rdata          <= '0;
      bresp          <= OKAY;
      rresp          <= OKAY;
      aw_got         <= 1'b0;
      w_got          <= 1'b0;
      last_was_write <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values.
      state  <= state_next;
      aw_got <= (state_next == WR_COLLECT) && (aw_got || aw_hs);
      w_got  <= (state_next == WR_COLLECT) && (w_got || w_hs);
      if (aw_hs) addr <= axi_s.awaddr;
      if (ar_hs) addr <= axi_s.araddr;
      if (w_hs) begin
        wr_data   <= axi_s.wdata;
        wr_strobe <= axi_s.wstrb;
      end
      // Only a genuine collision moves the round-robin pointer.
      if (state == IDLE && contested) last_was_write <= ~last_was_write;
      if (state == WR_EXEC) bresp <= access_fault ? SLVERR : OKAY;
      if (state == RD_WAIT) begin
        rdata <= rd_data;
        rresp <= access_fault ? SLVERR : OKAY;
      end
    end
  end

  assign rd_en         = (state == RD_EXEC);
  assign wr_en         = (state == WR_EXEC);
  assign axi_s.awready = aw_rdy;
  assign axi_s.wready  = w_rdy;
  assign axi_s.arready = ar_rdy;
  assign axi_s.bvalid  = (state == WR_RESP);
  assign axi_s.bresp   = bresp;
  assign axi_s.rvalid  = (state == RD_RESP);
  assign axi_s.rdata   = rdata;
  assign axi_s.rresp   = rresp;

endmodule
